// File: rtl/pe_fp_scheduler_pkg.sv
// Shared definitions for the binary-activation PE layer sequencer: FSM encoding,
// PE latency limits and the clogb2 width helper.
package pe_fp_scheduler_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned PE_LAT_MIN = 1;
  localparam int unsigned PE_LAT_MAX = 8;

  // Bits needed to index 0..value-1; never returns less than 1.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res = res + 1;
    if (res == 0) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/pe_fp_sched_counter.sv
// Nested filter/row/column position counter (column innermost) with the linear
// output-buffer address kept alongside as a running count.
module pe_fp_sched_counter
  import pe_fp_scheduler_pkg::*;
#(
  parameter int unsigned OUT_H     = 16,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned N_FILTERS = 64,
  localparam int unsigned ROW_W    = clogb2(OUT_H),
  localparam int unsigned COL_W    = clogb2(OUT_W),
  localparam int unsigned FILT_W   = clogb2(N_FILTERS),
  localparam int unsigned ADDR_W   = clogb2(N_FILTERS * OUT_H * OUT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_adv,
  output logic [ROW_W-1:0]  o_row,
  output logic [COL_W-1:0]  o_col,
  output logic [FILT_W-1:0] o_filt,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_c
);

  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [FILT_W-1:0] r_filt;
  logic [ADDR_W-1:0] r_addr;
  logic              w_col_end;
  logic              w_row_end;
  logic              w_filt_end;

  assign w_col_end  = (r_col  == COL_W'(OUT_W - 1));
  assign w_row_end  = (r_row  == ROW_W'(OUT_H - 1));
  assign w_filt_end = (r_filt == FILT_W'(N_FILTERS - 1));
  assign o_last_c   = w_col_end & w_row_end & w_filt_end;

  // The final tuple holds rather than wrapping; the sequencer leaves ISSUE on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_filt <= '0;
      r_addr <= '0;
    end else if (i_clr) begin
      r_row  <= '0;
      r_col  <= '0;
      r_filt <= '0;
      r_addr <= '0;
    end else if (i_adv && !o_last_c) begin
      r_addr <= r_addr + ADDR_W'(1);
      if (w_col_end) begin
        r_col <= '0;
        if (w_row_end) begin
          r_row  <= '0;
          r_filt <= r_filt + FILT_W'(1);
        end else begin
          r_row <= r_row + ROW_W'(1);
        end
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_filt = r_filt;
  assign o_addr = r_addr;

endmodule

// File: rtl/pe_fp_scheduler.sv
// Layer sequencer for one conv/pool/binarize PE: issues every (filt,row,col) fetch
// and writes the PE result back. Optional pool-index path: PE_FP_SCHED_PINDEX_EN.
module pe_fp_scheduler
  import pe_fp_scheduler_pkg::*;
#(
  parameter int unsigned OUT_H        = 16,
  parameter int unsigned OUT_W        = 16,
  parameter int unsigned N_FILTERS    = 64,
  parameter int unsigned PE_LATENCY   = 1,
  parameter int unsigned PE_OUT_WIDTH = 2,
  parameter int unsigned PINDEX_WIDTH = 2,
  localparam int unsigned ROW_W       = clogb2(OUT_H),
  localparam int unsigned COL_W       = clogb2(OUT_W),
  localparam int unsigned FILT_W      = clogb2(N_FILTERS),
  localparam int unsigned ADDR_W      = clogb2(N_FILTERS * OUT_H * OUT_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    fetch_valid,
  input  logic                    fetch_ready,
  output logic [ROW_W-1:0]        fetch_row,
  output logic [COL_W-1:0]        fetch_col,
  output logic [FILT_W-1:0]       fetch_filt,
  input  logic [PE_OUT_WIDTH-1:0] pe_data,
  input  logic [PINDEX_WIDTH-1:0] pe_pindex,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [PE_OUT_WIDTH-1:0] wr_data,
  output logic [PINDEX_WIDTH-1:0] wr_pindex
);

  // Out-of-range latencies are pulled back into the supported window.
  localparam int unsigned LAT = (PE_LATENCY < PE_LAT_MIN) ? PE_LAT_MIN :
                                (PE_LATENCY > PE_LAT_MAX) ? PE_LAT_MAX : PE_LATENCY;

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic                    w_cnt_clr;
  logic                    w_hs;
  logic                    w_last;
  logic [ADDR_W-1:0]       w_cnt_addr;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_fetch_valid;
  logic [LAT-1:0]          r_inf_vld;
  logic [ADDR_W*LAT-1:0]   r_inf_addr;
  logic [LAT-1:0]          w_inf_vld_nxt;
  logic [ADDR_W*LAT-1:0]   w_inf_addr_nxt;
  logic                    w_tail_vld;
  logic [ADDR_W-1:0]       w_tail_addr;
  logic                    r_wr_en;
  logic [ADDR_W-1:0]       r_wr_addr;
  logic [PE_OUT_WIDTH-1:0] r_wr_data;

  assign w_hs = r_fetch_valid & fetch_ready;

  pe_fp_sched_counter #(
    .OUT_H     (OUT_H),
    .OUT_W     (OUT_W),
    .N_FILTERS (N_FILTERS)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_cnt_clr),
    .i_adv    (w_hs),
    .o_row    (fetch_row),
    .o_col    (fetch_col),
    .o_filt   (fetch_filt),
    .o_addr   (w_cnt_addr),
    .o_last_c (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_ISSUE;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_ISSUE: if (w_hs && w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (~|r_inf_vld) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_fetch_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_done        <= (w_state_nxt == ST_DONE);
      r_fetch_valid <= (w_state_nxt == ST_ISSUE);
    end
  end

  if (LAT == 1) begin : g_lat1
    assign w_inf_vld_nxt  = w_hs;
    assign w_inf_addr_nxt = w_cnt_addr;
  end else begin : g_latn
    assign w_inf_vld_nxt  = {r_inf_vld[LAT-2:0], w_hs};
    assign w_inf_addr_nxt = {r_inf_addr[ADDR_W*(LAT-1)-1:0], w_cnt_addr};
  end

  assign w_tail_vld  = r_inf_vld[LAT-1];
  assign w_tail_addr = r_inf_addr[ADDR_W*LAT-1 -: ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inf_vld  <= '0;
      r_inf_addr <= '0;
    end else begin
      r_inf_vld  <= w_inf_vld_nxt;
      r_inf_addr <= w_inf_addr_nxt;
    end
  end

  // PE output is captured when its request reaches the tail; written next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_tail_vld;
      if (w_tail_vld) begin
        r_wr_addr <= w_tail_addr;
        r_wr_data <= pe_data;
      end
    end
  end

`ifdef PE_FP_SCHED_PINDEX_EN
  logic [PINDEX_WIDTH-1:0] r_wr_pindex;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_pindex <= '0;
    end else if (w_tail_vld) begin
      r_wr_pindex <= pe_pindex;
    end
  end

  assign wr_pindex = r_wr_pindex;
`else
  logic w_unused_pindex;
  assign w_unused_pindex = ^pe_pindex;
  assign wr_pindex       = '0;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign fetch_valid = r_fetch_valid;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;

endmodule

// File: tb/tb_pe_fp_scheduler.sv
// Scoreboard bench for pe_fp_scheduler: two instances (PE latency 1 and 3) on a
// 2x3x2 layer share start/ready stimulus; a per-instance PE model answers fetches.
module tb_pe_fp_scheduler;

  localparam int N_TUP = 12;

`ifdef PE_FP_SCHED_PINDEX_EN
  localparam logic [1:0] EXP_PIDX = 2'd2;
`else
  localparam logic [1:0] EXP_PIDX = 2'd0;
`endif

  typedef struct packed {
    logic [3:0] addr;
    int         hcyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       fetch_ready;
  logic [1:0] pe_pindex;
  logic       busy    [2];
  logic       done    [2];
  logic       fv      [2];
  logic       wr_en   [2];
  logic [0:0] frow    [2];
  logic [1:0] fcol    [2];
  logic [0:0] ffilt   [2];
  logic [3:0] waddr   [2];
  logic [1:0] wdata   [2];
  logic [1:0] wpidx   [2];
  logic [1:0] pe_data [2];

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   s_cyc  = 0;
  int   exp_k[2], n_hs[2], n_wr[2], n_done[2];
  int   first_hs[2], last_hs[2], first_wr[2], last_wr[2], done_cyc[2];
  bit   active[2], busy_chk[2];
  logic [1:0] pe_ring [2][16];
  exp_t q0[$];
  exp_t q1[$];

  pe_fp_scheduler #(
    .OUT_H(2), .OUT_W(3), .N_FILTERS(2), .PE_LATENCY(1), .PE_OUT_WIDTH(2), .PINDEX_WIDTH(2)
  ) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy[0]), .done(done[0]),
    .fetch_valid(fv[0]), .fetch_ready(fetch_ready), .fetch_row(frow[0]),
    .fetch_col(fcol[0]), .fetch_filt(ffilt[0]), .pe_data(pe_data[0]),
    .pe_pindex(pe_pindex), .wr_en(wr_en[0]), .wr_addr(waddr[0]),
    .wr_data(wdata[0]), .wr_pindex(wpidx[0])
  );

  pe_fp_scheduler #(
    .OUT_H(2), .OUT_W(3), .N_FILTERS(2), .PE_LATENCY(3), .PE_OUT_WIDTH(2), .PINDEX_WIDTH(2)
  ) u_dut_l3 (
    .clk(clk), .rst(rst), .start(start), .busy(busy[1]), .done(done[1]),
    .fetch_valid(fv[1]), .fetch_ready(fetch_ready), .fetch_row(frow[1]),
    .fetch_col(fcol[1]), .fetch_filt(ffilt[1]), .pe_data(pe_data[1]),
    .pe_pindex(pe_pindex), .wr_en(wr_en[1]), .wr_addr(waddr[1]),
    .wr_data(wdata[1]), .wr_pindex(wpidx[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Expected {filt,row,col} for the k-th request in filter/row/column order.
  function automatic logic [3:0] tuple_of(input int k);
    return {1'(k / 6), 1'((k % 6) / 3), 2'(k % 3)};
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic qpop(input int d, output exp_t e);
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
  endtask

  task automatic begin_layer();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      exp_k[d] = 0; n_hs[d] = 0; n_wr[d] = 0; n_done[d] = 0;
      first_hs[d] = -1; last_hs[d] = -1; first_wr[d] = -1; last_wr[d] = -1;
      done_cyc[d] = -1; active[d] = 1'b1; busy_chk[d] = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s_u%0d_busy", tag, d), 64'(busy[d]), 64'd0);
      check_eq($sformatf("%s_u%0d_done", tag, d), 64'(done[d]), 64'd0);
      check_eq($sformatf("%s_u%0d_fetch_valid", tag, d), 64'(fv[d]), 64'd0);
      check_eq($sformatf("%s_u%0d_wr_en", tag, d), 64'(wr_en[d]), 64'd0);
      check_eq($sformatf("%s_u%0d_coords", tag, d), 64'({ffilt[d], frow[d], fcol[d]}), 64'd0);
      check_eq($sformatf("%s_u%0d_wr_bus", tag, d), 64'({waddr[d], wdata[d], wpidx[d]}), 64'd0);
    end
  endtask

  // Monitor and PE model; inputs change just after posedge, so sample at negedge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      if (busy_chk[d]) begin
        check_eq($sformatf("u%0d_busy_drop", d), 64'(busy[d]), 64'd0);
        busy_chk[d] = 1'b0;
      end
      if (active[d] && cyc == s_cyc + 1) begin
        check_eq($sformatf("u%0d_busy_rise", d), 64'(busy[d]), 64'd1);
        check_eq($sformatf("u%0d_fv_rise", d), 64'(fv[d]), 64'd1);
      end
      if (fv[d] === 1'b1) begin
        check_eq($sformatf("u%0d_fetch_in_range", d), 64'(exp_k[d] < N_TUP), 64'd1);
        check_eq($sformatf("u%0d_coord_k%0d", d, exp_k[d]),
                 64'({ffilt[d], frow[d], fcol[d]}), 64'(tuple_of(exp_k[d])));
        if (fetch_ready) begin
          e.addr = 4'(exp_k[d]);
          e.hcyc = cyc;
          qpush(d, e);
          pe_ring[d][(cyc + lat_of(d)) % 16] = 2'(exp_k[d]);
          if (n_hs[d] == 0) first_hs[d] = cyc;
          last_hs[d] = cyc;
          n_hs[d]++;
          exp_k[d]++;
        end
      end
      if (wr_en[d] === 1'b1) begin
        check_eq($sformatf("u%0d_wr_expected", d), 64'(qsize(d) > 0), 64'd1);
        if (qsize(d) > 0) begin
          qpop(d, e);
          check_eq($sformatf("u%0d_wr_addr", d), 64'(waddr[d]), 64'(e.addr));
          check_eq($sformatf("u%0d_wr_data", d), 64'(wdata[d]), 64'(e.addr[1:0]));
          check_eq($sformatf("u%0d_wr_pindex", d), 64'(wpidx[d]), 64'(EXP_PIDX));
          check_eq($sformatf("u%0d_wr_latency", d), 64'(cyc - e.hcyc), 64'(lat_of(d) + 1));
        end
        if (n_wr[d] == 0) first_wr[d] = cyc;
        last_wr[d] = cyc;
        n_wr[d]++;
      end
      if (done[d] === 1'b1) begin
        check_eq($sformatf("u%0d_done_in_layer", d), 64'(active[d]), 64'd1);
        check_eq($sformatf("u%0d_busy_at_done", d), 64'(busy[d]), 64'd1);
        done_cyc[d] = cyc;
        n_done[d]++;
        active[d]   = 1'b0;
        busy_chk[d] = 1'b1;
      end
      pe_data[d] = pe_ring[d][cyc % 16];
    end
  end

  // mode 0: ready held high; mode 1: ready toggles 1,0,1,0 from the first fetch cycle.
  task automatic run_layer(input int mode, input bit pulse, input string name);
    int rel;
    begin_layer();
    @(posedge clk); #1;
    s_cyc       = cyc;
    start       = 1'b1;
    fetch_ready = 1'b1;
    for (int i = 0; i < 200 && !(n_done[0] > 0 && n_done[1] > 0); i++) begin
      @(posedge clk); #1;
      rel         = cyc - s_cyc;
      fetch_ready = (mode == 0) ? 1'b1 : rel[0];
      start       = pulse && (rel == 5 || rel == 9 || rel == 14 || rel == 15);
    end
    start       = 1'b0;
    fetch_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s_u%0d_hs_count", name, d), 64'(n_hs[d]), 64'(N_TUP));
      check_eq($sformatf("%s_u%0d_wr_count", name, d), 64'(n_wr[d]), 64'(N_TUP));
      check_eq($sformatf("%s_u%0d_done_count", name, d), 64'(n_done[d]), 64'd1);
      check_eq($sformatf("%s_u%0d_pending", name, d), 64'(qsize(d)), 64'd0);
      check_eq($sformatf("%s_u%0d_done_vs_hs", name, d), 64'(done_cyc[d] - last_hs[d]),
               64'(lat_of(d) + 2));
      check_eq($sformatf("%s_u%0d_done_vs_wr", name, d), 64'(done_cyc[d] - last_wr[d]), 64'd1);
      check_eq($sformatf("%s_u%0d_idle_busy", name, d), 64'(busy[d]), 64'd0);
      check_eq($sformatf("%s_u%0d_idle_fv", name, d), 64'(fv[d]), 64'd0);
      if (mode == 0) begin
        check_eq($sformatf("%s_u%0d_first_hs", name, d), 64'(first_hs[d] - s_cyc), 64'd1);
        check_eq($sformatf("%s_u%0d_last_hs", name, d), 64'(last_hs[d] - s_cyc), 64'(N_TUP));
        check_eq($sformatf("%s_u%0d_first_wr", name, d), 64'(first_wr[d] - s_cyc),
                 64'(lat_of(d) + 2));
        check_eq($sformatf("%s_u%0d_done_cyc", name, d), 64'(done_cyc[d] - s_cyc),
                 64'(N_TUP + lat_of(d) + 2));
      end
    end
  endtask

  // Reset lands in layer cycle 6: outputs clear at once and the layer never completes.
  task automatic run_abort();
    begin_layer();
    @(posedge clk); #1;
    s_cyc       = cyc;
    start       = 1'b1;
    fetch_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      active[d]   = 1'b0;
      busy_chk[d] = 1'b0;
    end
    #1;
    check_reset_outputs("abort");
    check_eq("abort_u0_wr_before", 64'(n_wr[0]), 64'd3);
    check_eq("abort_u1_wr_before", 64'(n_wr[1]), 64'd1);
    check_eq("abort_hs_before", 64'(n_hs[0] + n_hs[1]), 64'd10);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("abort_u%0d_no_more_wr", d), 64'(n_wr[d]), 64'(d == 0 ? 3 : 1));
      check_eq($sformatf("abort_u%0d_no_done", d), 64'(n_done[d]), 64'd0);
      check_eq($sformatf("abort_u%0d_idle", d), 64'({busy[d], fv[d]}), 64'd0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    fetch_ready = 1'b1;
    pe_pindex   = 2'd2;
    for (int d = 0; d < 2; d++) begin
      active[d]   = 1'b0;
      busy_chk[d] = 1'b0;
      pe_data[d]  = 2'd0;
      for (int i = 0; i < 16; i++) pe_ring[d][i] = 2'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    run_layer(0, 1'b0, "full");
    run_layer(1, 1'b0, "toggle");
    run_layer(0, 1'b1, "restart");
    run_abort();
    run_layer(0, 1'b0, "post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
